y86_run_monitor: RTL and testbench

- Synthesizable run controller and trace monitor for the single-cycle Y86-64 core. Replaces the fixed-time testbench harness.
- Gates the core with a clock enable. Counts cycles and retired instructions.
- Stops the run on a non-AOK status, a cycle limit, or an abort. Records the PC, icode and ifun of each executed instruction in a parametrised trace FIFO.
- Sits between the core wrapper and the bench or debug host.

---
 rtl/y86_run_monitor_if.sv | 42 ++++
 rtl/y86_run_monitor.sv | 144 ++++++++++++++
 tb/tb_y86_run_monitor.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/y86_run_monitor_if.sv
// Signal bundle between the run monitor and its host/core side.
// master = bench or debug host plus core wrapper; slave = y86_run_monitor.
interface y86_run_monitor_if #(
  parameter int PC_W        = 64,
  parameter int TRACE_DEPTH = 16,
  parameter int CYCLE_W     = 32
);
  localparam int LVL_W = $clog2(TRACE_DEPTH) + 1;

  logic               start;
  logic               abort;
  logic [CYCLE_W-1:0] cycle_limit;
  logic               cpu_en;
  logic [PC_W-1:0]    pc;
  logic [3:0]         icode;
  logic [3:0]         ifun;
  logic [1:0]         stat;
  logic               busy;
  logic               done;
  logic [2:0]         halt_reason;
  logic [CYCLE_W-1:0] cycle_count;
  logic [CYCLE_W-1:0] instr_count;
  logic               trace_rd;
  logic               trace_valid;
  logic [PC_W-1:0]    trace_pc;
  logic [3:0]         trace_icode;
  logic [3:0]         trace_ifun;
  logic [LVL_W-1:0]   trace_level;
  logic               trace_ovf;

  modport master (
    output start, abort, cycle_limit, pc, icode, ifun, stat, trace_rd,
    input  cpu_en, busy, done, halt_reason, cycle_count, instr_count,
           trace_valid, trace_pc, trace_icode, trace_ifun, trace_level, trace_ovf
  );

  modport slave (
    input  start, abort, cycle_limit, pc, icode, ifun, stat, trace_rd,
    output cpu_en, busy, done, halt_reason, cycle_count, instr_count,
           trace_valid, trace_pc, trace_icode, trace_ifun, trace_level, trace_ovf
  );
endinterface

// File: rtl/y86_run_monitor.sv
// Run controller and instruction trace FIFO for the single-cycle Y86-64 core.
// Define TRACE_WRAP_EN to keep the newest entries on overflow instead of the oldest.
module y86_run_monitor #(
  parameter int PC_W        = 64,
  parameter int TRACE_DEPTH = 16,
  parameter int CYCLE_W     = 32
) (
  input logic              clk,
  input logic              rst_n,
  y86_run_monitor_if.slave mon
);
  localparam int AW    = $clog2(TRACE_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int ENT_W = PC_W + 8;

  localparam logic [2:0] R_NONE    = 3'd0;
  localparam logic [2:0] R_TIMEOUT = 3'd4;
  localparam logic [2:0] R_ABORT   = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [2:0]         reason, reason_nxt;
  logic [CYCLE_W-1:0] cycle_cnt, instr_cnt, limit;
  logic [CYCLE_W-1:0] cycle_inc, instr_inc;
  logic               start_ok, run;

  logic [ENT_W-1:0]   mem [TRACE_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level;
  logic               full, push, pop, wr_en, rd_adv, lost;

  assign run       = (state == S_RUN);
  assign start_ok  = mon.start && !run;
  assign cycle_inc = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CYCLE_W'(1);
  assign instr_inc = (instr_cnt == '1) ? instr_cnt : instr_cnt + CYCLE_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      reason <= R_NONE;
    end else begin
      state  <= state_nxt;
      reason <= reason_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    reason_nxt = reason;
    case (state)
      S_IDLE, S_DONE: begin
        if (mon.start) begin
          if (mon.cycle_limit == '0) begin
            state_nxt  = S_DONE;
            reason_nxt = R_TIMEOUT;
          end else begin
            state_nxt  = S_RUN;
            reason_nxt = R_NONE;
          end
        end
      end
      S_RUN: begin
        // Core fault outranks abort, which outranks the cycle limit.
        if (mon.stat != 2'd0) begin
          state_nxt  = S_DONE;
          reason_nxt = {1'b0, mon.stat};
        end else if (mon.abort) begin
          state_nxt  = S_DONE;
          reason_nxt = R_ABORT;
        end else if (cycle_inc == limit) begin
          state_nxt  = S_DONE;
          reason_nxt = R_TIMEOUT;
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        reason_nxt = R_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
      limit     <= '0;
    end else if (start_ok) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
      limit     <= mon.cycle_limit;
    end else if (run) begin
      cycle_cnt <= cycle_inc;
      if (mon.stat == 2'd0) instr_cnt <= instr_inc;
    end
  end

  assign full = (level == LVL_W'(TRACE_DEPTH));
  assign push = run;
  assign pop  = mon.trace_rd && (level != '0);
  assign lost = push && full && !pop;

`ifdef TRACE_WRAP_EN
  assign wr_en  = push;
  assign rd_adv = pop || lost;
`else
  assign wr_en  = push && !lost;
  assign rd_adv = pop;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {mon.pc, mon.icode, mon.ifun};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      mon.trace_ovf   <= 1'b0;
    end else if (start_ok) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      mon.trace_ovf   <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + AW'(1);
      if (rd_adv) rd_ptr <= rd_ptr + AW'(1);
      if (push && !full && !pop)  level <= level + LVL_W'(1);
      else if (pop && !push)      level <= level - LVL_W'(1);
      if (lost) mon.trace_ovf <= 1'b1;
    end
  end

  assign mon.cpu_en      = run;
  assign mon.busy        = run;
  assign mon.done        = (state == S_DONE);
  assign mon.halt_reason = reason;
  assign mon.cycle_count = cycle_cnt;
  assign mon.instr_count = instr_cnt;
  assign mon.trace_valid = (level != '0);
  assign mon.trace_level = level;
  assign {mon.trace_pc, mon.trace_icode, mon.trace_ifun} = mem[rd_ptr];
endmodule

// File: tb/tb_y86_run_monitor.sv
// Directed bench for y86_run_monitor; a small core model steps a program while cpu_en is high.
module tb_y86_run_monitor;
  localparam int PC_W        = 64;
  localparam int TRACE_DEPTH = 16;
  localparam int CYCLE_W     = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  y86_run_monitor_if #(.PC_W(PC_W), .TRACE_DEPTH(TRACE_DEPTH), .CYCLE_W(CYCLE_W)) bus ();

  y86_run_monitor #(.PC_W(PC_W), .TRACE_DEPTH(TRACE_DEPTH), .CYCLE_W(CYCLE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  int          step        = 0;
  int          en_cnt      = 0;
  int          fault_step  = -1;
  logic [1:0]  fault_stat  = 2'd0;
  logic [3:0]  fault_icode = 4'd0;
  logic [3:0]  prog_icode  = 4'd1;
  logic [63:0] pc_base     = 64'h0;
  logic        loop_pc     = 1'b0;

  // Core model: one instruction per enabled cycle, restarted by start.
  always @(posedge clk) begin
    if (bus.start) begin
      step   <= 0;
      en_cnt <= 0;
    end else if (bus.cpu_en) begin
      step   <= step + 1;
      en_cnt <= en_cnt + 1;
    end
  end

  always_comb begin
    bus.pc   = loop_pc ? pc_base : pc_base + 64'(step);
    bus.ifun = 4'd0;
    if (step == fault_step) begin
      bus.icode = fault_icode;
      bus.stat  = fault_stat;
    end else begin
      bus.icode = prog_icode;
      bus.stat  = 2'd0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int lim);
    bus.cycle_limit = CYCLE_W'(lim);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      tick();
      n++;
    end
    check("done_wait", 64'(bus.done), 64'd1);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.trace_rd    = 1'b0;
    bus.cycle_limit = '0;

    #3;
    check("rst_cpu_en", 64'(bus.cpu_en), 64'd0);
    check("rst_busy",   64'(bus.busy),   64'd0);
    check("rst_done",   64'(bus.done),   64'd0);
    check("rst_reason", 64'(bus.halt_reason), 64'd0);
    check("rst_cycles", 64'(bus.cycle_count), 64'd0);
    check("rst_instrs", 64'(bus.instr_count), 64'd0);
    check("rst_valid",  64'(bus.trace_valid), 64'd0);
    check("rst_level",  64'(bus.trace_level), 64'd0);
    check("rst_ovf",    64'(bus.trace_ovf),   64'd0);
    #9 rst_n = 1'b1;
    tick();

    // nop x5 then halt
    pc_base = 64'h100; prog_icode = 4'd1; fault_step = 5; fault_stat = 2'd1; fault_icode = 4'd0;
    start_run(100);
    check("hlt_busy", 64'(bus.cpu_en), 64'd1);
    wait_done(50);
    check("hlt_en_cycles", 64'(en_cnt), 64'd6);
    check("hlt_reason", 64'(bus.halt_reason), 64'd1);
    check("hlt_cycles", 64'(bus.cycle_count), 64'd6);
    check("hlt_instrs", 64'(bus.instr_count), 64'd5);
    check("hlt_level",  64'(bus.trace_level), 64'd6);
    check("hlt_cpu_en_off", 64'(bus.cpu_en), 64'd0);
    check("hlt_head_pc", bus.trace_pc, 64'h100);
    check("hlt_head_icode", 64'(bus.trace_icode), 64'd1);
    bus.trace_rd = 1'b1;
    repeat (5) tick();
    bus.trace_rd = 1'b0;
    check("hlt_pop_level", 64'(bus.trace_level), 64'd1);
    check("hlt_last_pc", bus.trace_pc, 64'h105);
    check("hlt_last_icode", 64'(bus.trace_icode), 64'd0);

    // infinite jmp loop, limit 20
    pc_base = 64'h200; loop_pc = 1'b1; prog_icode = 4'd7; fault_step = -1;
    start_run(20);
    wait_done(60);
    check("to_en_cycles", 64'(en_cnt), 64'd20);
    check("to_reason", 64'(bus.halt_reason), 64'd4);
    check("to_cycles", 64'(bus.cycle_count), 64'd20);
    check("to_instrs", 64'(bus.instr_count), 64'd20);
    check("to_ovf", 64'(bus.trace_ovf), 64'd1);
    loop_pc = 1'b0; prog_icode = 4'd1;

    // zero limit goes straight to DONE and clears the previous run
    start_run(0);
    check("zl_done", 64'(bus.done), 64'd1);
    check("zl_cpu_en", 64'(bus.cpu_en), 64'd0);
    check("zl_reason", 64'(bus.halt_reason), 64'd4);
    check("zl_cycles", 64'(bus.cycle_count), 64'd0);
    check("zl_ovf_clr", 64'(bus.trace_ovf), 64'd0);
    check("zl_level", 64'(bus.trace_level), 64'd0);
    tick();
    check("zl_en_cycles", 64'(en_cnt), 64'd0);

    // abort sampled on run cycle 3
    pc_base = 64'h300;
    start_run(100);
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("ab_done", 64'(bus.done), 64'd1);
    check("ab_reason", 64'(bus.halt_reason), 64'd5);
    check("ab_cycles", 64'(bus.cycle_count), 64'd3);
    check("ab_en_cycles", 64'(en_cnt), 64'd3);
    check("ab_level", 64'(bus.trace_level), 64'd3);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("ab_idle_reason", 64'(bus.halt_reason), 64'd5);
    check("ab_idle_cycles", 64'(bus.cycle_count), 64'd3);

    // ADR, abort and limit all on the same edge
    pc_base = 64'h400; fault_step = 3; fault_stat = 2'd2; fault_icode = 4'd5;
    start_run(4);
    repeat (3) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("sim_reason", 64'(bus.halt_reason), 64'd2);
    check("sim_cycles", 64'(bus.cycle_count), 64'd4);
    check("sim_instrs", 64'(bus.instr_count), 64'd3);
    fault_step = -1;

    // 20 instructions into a 16-entry FIFO with no reads
    pc_base = 64'h2000;
    start_run(20);
    wait_done(60);
    check("ovf_level", 64'(bus.trace_level), 64'd16);
    check("ovf_flag", 64'(bus.trace_ovf), 64'd1);
    check("ovf_instrs", 64'(bus.instr_count), 64'd20);
`ifdef TRACE_WRAP_EN
    check("ovf_head_pc", bus.trace_pc, 64'h2004);
`else
    check("ovf_head_pc", bus.trace_pc, 64'h2000);
`endif

    // fill, then pop every cycle while full
    pc_base = 64'h4000;
    start_run(30);
    check("rs_busy", 64'(bus.busy), 64'd1);
    check("rs_cycles_clr", 64'(bus.cycle_count), 64'd0);
    check("rs_level_clr", 64'(bus.trace_level), 64'd0);
    check("rs_ovf_clr", 64'(bus.trace_ovf), 64'd0);
    repeat (16) tick();
    check("pp_full_level", 64'(bus.trace_level), 64'd16);
    bus.trace_rd = 1'b1;
    repeat (7) tick();
    check("pp_mid_level", 64'(bus.trace_level), 64'd16);
    repeat (7) tick();
    bus.trace_rd = 1'b0;
    check("pp_done", 64'(bus.done), 64'd1);
    check("pp_cycles", 64'(bus.cycle_count), 64'd30);
    check("pp_level", 64'(bus.trace_level), 64'd16);
    check("pp_ovf", 64'(bus.trace_ovf), 64'd0);
    check("pp_head_pc", bus.trace_pc, 64'h400E);

    // asynchronous reset in the middle of a run
    start_run(100);
    repeat (3) tick();
    check("mr_running", 64'(bus.cpu_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mr_cpu_en", 64'(bus.cpu_en), 64'd0);
    check("mr_busy", 64'(bus.busy), 64'd0);
    check("mr_cycles", 64'(bus.cycle_count), 64'd0);
    check("mr_level", 64'(bus.trace_level), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    check("mr_idle", 64'(bus.busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
